pr_region_ctrl: RTL and testbench
=================================

# pr_region_ctrl

Controller for one dynamically reconfigurable LED region (e.g. the 2-bit LED shifter module). It arbitrates reconfiguration requests from the secure and non-secure worlds, with secure priority and a policy gate on non-secure. It sequences each reconfiguration: decouple, hold the module in reset, start the bitstream loader, wait for completion or failure, then release. It sits between the processor-side request registers and the partial-reconfiguration loader / region isolation logic.

## Interface
- `TIMEOUT`, 1000: max cycles in WAIT before declaring timeout; legal 2..65535.
- `RST_HOLD`, 4: cycles the module reset stays asserted after load completes, and during post-reset INIT; legal 1..255.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_req` in 1: secure-world reconfiguration request, level.
- `ns_req` in 1: non-secure-world reconfiguration request, level.
- `ns_allowed` in 1: policy bit; 1 = non-secure may reconfigure.
- `pr_done` in 1: loader completion pulse.
- `pr_err` in 1: loader error pulse.
- `s_gnt` out 1: secure request accepted and owned.
- `ns_gnt` out 1: non-secure request accepted and owned.
- `pr_start` out 1: one-cycle start pulse to the loader.
- `decouple` out 1: isolates region outputs.
- `rm_rst` out 1: active-high reset to the reconfigurable module.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle completion pulse; also pulses for a denied request.
- `err_code` out 2: 00 ok, 01 loader error, 10 timeout, 11 denied. Held until the next accept or deny.

## Operation
- States: INIT, IDLE, ISOLATE, START, WAIT, HOLD, RELEASE, DONE, FAIL, DENY, DROP.
- INIT (entered from reset): decouple=1, rm_rst=1 for RST_HOLD cycles, then go to IDLE with rm_rst=0 and decouple=0.
- IDLE arbitration, evaluated on each cycle:
  - s_req=1 → accept secure.
  - Else ns_req=1 and ns_allowed=1 → accept non-secure.
  - Else ns_req=1 and ns_allowed=0 → DENY.
- Accept: set the matching gnt, clear err_code, go to ISOLATE.
  - ISOLATE lasts 2 cycles with decouple=1, rm_rst=1.
  - Then START for 1 cycle with pr_start=1; the timeout counter clears.
  - Then WAIT.
- WAIT: counter increments each cycle.
  - pr_err=1 → FAIL with code 01.
  - Else pr_done=1 → HOLD.
  - Else counter==TIMEOUT-1 → FAIL with code 10.
- HOLD: rm_rst=1, decouple=1 for RST_HOLD cycles. Then RELEASE for 1 cycle: rm_rst=0, decouple=1.
- DONE, 1 cycle: decouple=0, done=1, err_code=00, then DROP.
- FAIL, 1 cycle: done=1, err_code set; region stays decouple=1, rm_rst=1 until a later successful reconfiguration. Then DROP.
- DENY, 1 cycle: done=1, err_code=11; no gnt, no decouple, no pr_start. Then DROP.
- DROP: hold gnt until the owning request deasserts, then drop gnt and go to IDLE. For DENY, wait for ns_req=0.
- pr_done/pr_err outside WAIT are ignored.
- Requester deasserting req mid-sequence does not abort; the sequence completes.
- ns_allowed is sampled only in IDLE.

## Timing
- Reset values: s_gnt=0, ns_gnt=0, pr_start=0, decouple=1, rm_rst=1, busy=1 (INIT), done=0, err_code=00.
- All outputs are registered.
- Request high in IDLE at edge N → gnt=1, decouple=1, rm_rst=1 from N+1. pr_start is high for the cycle starting at N+3.
- pr_done at edge M → rm_rst falls at M+RST_HOLD+1. decouple falls and done pulses at M+RST_HOLD+2.
- Timeout: with no pr_done/pr_err, FAIL is entered TIMEOUT cycles after WAIT entry.
- Simultaneous events:
  - s_req and ns_req together: secure wins. ns stays pending and is served after DROP→IDLE if still asserted.
  - pr_err with pr_done: error wins.
  - pr_done on the timeout cycle: done wins.
- rst_n low mid-sequence: immediate return to reset values; restart in INIT. The loader is not notified.

## Test plan
- Reset release, no requests → rm_rst and decouple fall after 4 cycles (RST_HOLD=4); busy=0; outputs quiet.
- s_req=1 at edge N, pr_done 10 cycles after pr_start, s_req drops after done → s_gnt=1 from N+1; pr_start in cycle N+3; done with err_code=00; s_gnt=0 one cycle after s_req=0.
- s_req and ns_req high in the same cycle (ns_allowed=1) → secure sequence runs first; ns_gnt rises only after s_gnt drops; two done pulses.
- ns_req=1, ns_allowed=0 → done pulse with err_code=11; pr_start, decouple and rm_rst never toggle.
- TIMEOUT=20, no pr_done → FAIL 20 cycles after WAIT entry; err_code=10; decouple=1 and rm_rst=1 held. A following secure retry with pr_done clears both.
- pr_err and pr_done in the same cycle → err_code=01. Separately, rst_n pulsed low during WAIT → outputs return to reset values and INIT reruns.

Source files
------------

// File: rtl/pr_region_ctrl.sv
// Reconfiguration sequencer for one partial-reconfiguration LED region: arbitrates secure and
// non-secure requests, then walks decouple / reset / load / release with registered outputs.
module pr_region_ctrl #(
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_req,
  input  logic       ns_req,
  input  logic       ns_allowed,
  input  logic       pr_done,
  input  logic       pr_err,
  output logic       s_gnt,
  output logic       ns_gnt,
  output logic       pr_start,
  output logic       decouple,
  output logic       rm_rst,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code
);

  typedef enum logic [3:0] {
    StInit,
    StIdle,
    StIsolate,
    StStart,
    StWait,
    StHold,
    StRelease,
    StDone,
    StFail,
    StDeny,
    StDrop
  } state_e;

  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);
  localparam logic [15:0] HoldLast = 16'(RST_HOLD - 1);

  state_e      state;
  logic [15:0] cnt;
  logic        owner_released;

  // With no grant held, DROP is finishing a denied non-secure request.
  assign owner_released = (s_gnt && !s_req) || (ns_gnt && !ns_req) ||
                          (!s_gnt && !ns_gnt && !ns_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StInit;
      cnt      <= '0;
      s_gnt    <= 1'b0;
      ns_gnt   <= 1'b0;
      pr_start <= 1'b0;
      decouple <= 1'b1;
      rm_rst   <= 1'b1;
      busy     <= 1'b1;
      done     <= 1'b0;
      err_code <= 2'b00;
    end else begin
      pr_start <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        StInit: begin
          if (cnt == HoldLast) begin
            state    <= StIdle;
            cnt      <= '0;
            decouple <= 1'b0;
            rm_rst   <= 1'b0;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StIdle: begin
          cnt <= '0;
          if (s_req) begin
            state    <= StIsolate;
            s_gnt    <= 1'b1;
            err_code <= 2'b00;
            decouple <= 1'b1;
            rm_rst   <= 1'b1;
            busy     <= 1'b1;
          end else if (ns_req && ns_allowed) begin
            state    <= StIsolate;
            ns_gnt   <= 1'b1;
            err_code <= 2'b00;
            decouple <= 1'b1;
            rm_rst   <= 1'b1;
            busy     <= 1'b1;
          end else if (ns_req) begin
            state    <= StDeny;
            done     <= 1'b1;
            err_code <= 2'b11;
            busy     <= 1'b1;
          end
        end
        StIsolate: begin
          if (cnt == 16'd1) begin
            state    <= StStart;
            pr_start <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StStart: begin
          state <= StWait;
          cnt   <= '0;
        end
        StWait: begin
          if (pr_err) begin
            state    <= StFail;
            done     <= 1'b1;
            err_code <= 2'b01;
          end else if (pr_done) begin
            state <= StHold;
            cnt   <= '0;
          end else if (cnt == WaitLast) begin
            state    <= StFail;
            done     <= 1'b1;
            err_code <= 2'b10;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StHold: begin
          if (cnt == HoldLast) begin
            state  <= StRelease;
            rm_rst <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StRelease: begin
          state    <= StDone;
          decouple <= 1'b0;
          done     <= 1'b1;
          err_code <= 2'b00;
        end
        StDone:  state <= StDrop;
        StFail:  state <= StDrop;
        StDeny:  state <= StDrop;
        StDrop: begin
          if (owner_released) begin
            state  <= StIdle;
            s_gnt  <= 1'b0;
            ns_gnt <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: state <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_pr_region_ctrl.sv
// Randomised bench for pr_region_ctrl: every output is compared each cycle against a schedule
// derived from request/loader event times.
module tb_pr_region_ctrl;

  localparam int unsigned Timeout = 20;
  localparam int unsigned RstHold = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_req, ns_req, ns_allowed, pr_done, pr_err;
  logic       s_gnt, ns_gnt, pr_start, decouple, rm_rst, busy, done;
  logic [1:0] err_code;

  logic       e_sg, e_nsg, e_ps, e_dec, e_rst, e_busy, e_done;
  logic [1:0] e_err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic        fail_sticky;
  logic [1:0]  err_exp;

  always #5 clk = ~clk;

  pr_region_ctrl #(
    .TIMEOUT (Timeout),
    .RST_HOLD(RstHold)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_req     (s_req),
    .ns_req    (ns_req),
    .ns_allowed(ns_allowed),
    .pr_done   (pr_done),
    .pr_err    (pr_err),
    .s_gnt     (s_gnt),
    .ns_gnt    (ns_gnt),
    .pr_start  (pr_start),
    .decouple  (decouple),
    .rm_rst    (rm_rst),
    .busy      (busy),
    .done      (done),
    .err_code  (err_code)
  );

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".s_gnt"}, {3'b0, s_gnt}, {3'b0, e_sg});
    check_eq({tag, ".ns_gnt"}, {3'b0, ns_gnt}, {3'b0, e_nsg});
    check_eq({tag, ".pr_start"}, {3'b0, pr_start}, {3'b0, e_ps});
    check_eq({tag, ".decouple"}, {3'b0, decouple}, {3'b0, e_dec});
    check_eq({tag, ".rm_rst"}, {3'b0, rm_rst}, {3'b0, e_rst});
    check_eq({tag, ".busy"}, {3'b0, busy}, {3'b0, e_busy});
    check_eq({tag, ".done"}, {3'b0, done}, {3'b0, e_done});
    check_eq({tag, ".err_code"}, {2'b0, err_code}, {2'b0, e_err});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_reset_exp();
    e_sg = 0; e_nsg = 0; e_ps = 0; e_dec = 1; e_rst = 1; e_busy = 1; e_done = 0; e_err = 2'b00;
  endtask

  task automatic set_idle_exp();
    e_sg = 0; e_nsg = 0; e_ps = 0; e_dec = fail_sticky; e_rst = fail_sticky;
    e_busy = 0; e_done = 0; e_err = err_exp;
  endtask

  task automatic do_reset();
    s_req = 0; ns_req = 0; ns_allowed = 0; pr_done = 0; pr_err = 0;
    rst_n = 1'b0;
    #1;
    set_reset_exp();
    check_all("rst_async");
    repeat (2) tick("rst_low");
    rst_n = 1'b1;
    fail_sticky = 1'b0;
    err_exp = 2'b00;
    for (int i = 1; i <= int'(RstHold); i++) begin
      if (i == int'(RstHold)) set_idle_exp();
      else set_reset_exp();
      tick("init");
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      s_req = 0; ns_req = 0;
      ns_allowed = 1'($urandom_range(0, 1));
      pr_done = ($urandom_range(0, 3) == 0);
      pr_err = ($urandom_range(0, 3) == 0);
      set_idle_exp();
      tick("idle");
    end
  endtask

  // kind: 0 load ok, 1 loader error, 2 error+done together, 3 no response (timeout).
  // d: WAIT cycles before the loader answers (1..Timeout); rel: edge index at which the
  // request is seen low (0 = right when DROP first looks). Edge index 0 is the accept edge.
  task automatic run_grant(input bit sec, input int kind, input int d, input int rel,
                           input bit both, input int abort_at);
    int         r, fin, rel_at, idle_at;
    bit         ok;
    logic [1:0] code;
    string      tg;
    ok      = (kind == 0);
    r       = (kind == 3) ? 3 + int'(Timeout) : 3 + d;
    fin     = ok ? r + int'(RstHold) + 1 : r;
    rel_at  = (rel == 0) ? fin + 2 : rel;
    idle_at = (rel_at > fin + 2) ? rel_at : fin + 2;
    code    = ok ? 2'b00 : ((kind == 3) ? 2'b10 : 2'b01);
    tg      = sec ? "sec" : "ns";
    for (int i = 0; i <= idle_at; i++) begin
      if (abort_at != 0 && i == abort_at) begin
        do_reset();
        return;
      end
      if (sec) begin
        s_req  = (i < rel_at);
        ns_req = both;
      end else begin
        s_req  = 1'b0;
        ns_req = (i < rel_at);
      end
      ns_allowed = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      pr_done = 1'b0;
      pr_err  = 1'b0;
      if (i == r) begin
        pr_done = (kind == 0 || kind == 2);
        pr_err  = (kind == 1 || kind == 2);
      end else if ((i >= 1 && i <= 3) || i > r) begin
        pr_done = ($urandom_range(0, 3) == 0);
        pr_err  = ($urandom_range(0, 3) == 0);
      end
      e_sg   = sec && (i < idle_at);
      e_nsg  = !sec && (i < idle_at);
      e_ps   = (i == 2);
      e_busy = (i < idle_at);
      e_done = (i == fin);
      e_err  = (i >= fin) ? code : 2'b00;
      e_dec  = ok ? (i < fin) : 1'b1;
      e_rst  = ok ? (i < r + int'(RstHold)) : 1'b1;
      tick(tg);
    end
    fail_sticky = !ok;
    err_exp     = code;
  endtask

  task automatic run_deny(input int rel);
    int rel_at, idle_at;
    rel_at  = (rel < 1) ? 1 : rel;
    idle_at = (rel_at > 2) ? rel_at : 2;
    for (int i = 0; i <= idle_at; i++) begin
      s_req      = 1'b0;
      ns_req     = (i < rel_at);
      ns_allowed = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      pr_done    = ($urandom_range(0, 3) == 0);
      pr_err     = ($urandom_range(0, 3) == 0);
      e_sg = 0; e_nsg = 0; e_ps = 0; e_dec = fail_sticky; e_rst = fail_sticky;
      e_busy = (i < idle_at);
      e_done = (i == 0);
      e_err  = 2'b11;
      tick("deny");
    end
    err_exp = 2'b11;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    s_req = 0; ns_req = 0; ns_allowed = 0; pr_done = 0; pr_err = 0;
    fail_sticky = 0; err_exp = 2'b00;
    rst_n = 1'b1;
    #1;
    do_reset();
    idle_cycles(3);

    run_grant(1, 0, 10, 0, 0, 0);
    idle_cycles(2);
    run_grant(1, 0, 5, 0, 1, 0);
    run_grant(0, 0, 3, 0, 0, 0);
    idle_cycles(2);
    run_deny(3);
    idle_cycles(1);
    run_grant(1, 3, 1, 0, 0, 0);
    idle_cycles(3);
    run_deny(1);
    run_grant(1, 0, 4, 0, 0, 0);
    idle_cycles(1);
    run_grant(0, 2, 6, 2, 0, 0);
    run_grant(1, 0, int'(Timeout), 0, 0, 0);
    idle_cycles(1);
    run_grant(1, 3, 1, 0, 0, 8);
    idle_cycles(2);

    for (int t = 0; t < 40; t++) begin
      int sel, kind, d, rel;
      sel  = $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      d    = $urandom_range(1, Timeout);
      rel  = $urandom_range(0, 30);
      unique case (sel)
        0: run_grant(1, kind, d, rel, 0, 0);
        1: run_grant(0, kind, d, rel, 0, 0);
        2: begin
          run_grant(1, kind, d, rel, 1, 0);
          run_grant(0, $urandom_range(0, 3), $urandom_range(1, Timeout),
                    $urandom_range(0, 30), 0, 0);
        end
        default: run_deny($urandom_range(1, 6));
      endcase
      idle_cycles($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
